// File: rtl/eth_rx_fcs_check.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_fcs_check
// Purpose  : Receive-side Ethernet FCS checker. Runs the reflected CRC-32
//            (poly 0xEDB88320, byte-wide unrolled) over DA..FCS, strips the
//            trailing 4 FCS bytes with a 4-byte delay line and reports
//            CRC / length / PHY-error status at end of frame.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            in_valid/in_data/in_last/in_err - byte stream from deserializer
//            out_valid/out_data/out_last     - payload stream, FCS removed
//            frame_done         - one-cycle end-of-frame strobe
//            frame_ok/crc_err/len_err/phy_err - status, held until next done
//            stat_good/stat_crc_err - frame counters
// Options  : RX_FCS_STATS_EN - when defined, builds the saturating frame
//            counters; otherwise both counter outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module eth_rx_fcs_check #(
   parameter int MIN_FRAME = 64,
   parameter int MAX_FRAME = 1518,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   input  logic             in_err,
   output logic             out_valid,
   output logic [7:0]       out_data,
   output logic             out_last,
   output logic             frame_done,
   output logic             frame_ok,
   output logic             crc_err,
   output logic             len_err,
   output logic             phy_err,
   output logic [CNT_W-1:0] stat_good,
   output logic [CNT_W-1:0] stat_crc_err
);

   localparam logic [31:0]      c_poly    = 32'hEDB88320;
   localparam logic [31:0]      c_residue = 32'hDEBB20E3;
   localparam logic [31:0]      c_min_len = 32'(MIN_FRAME);
   localparam logic [31:0]      c_max_len = 32'(MAX_FRAME);
   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   logic [31:0]       crc_q, crc_d;
   logic [3:0][7:0]   dly_q, dly_d;      // [0] newest, [3] oldest
   logic [2:0]        fill_q, fill_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              phy_q, phy_d;

   logic              out_valid_q, out_valid_d;
   logic [7:0]        out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic              done_q, done_d;
   logic              ok_q, ok_d;
   logic              crc_err_q, crc_err_d;
   logic              len_err_q, len_err_d;
   logic              phy_err_q, phy_err_d;

   logic [31:0]       w_crc_upd;
   logic [CNT_W-1:0]  w_len;
   logic [31:0]       w_len32;
   logic              w_eof;
   logic              w_emit;

   always_comb begin
      // Byte-wide CRC step: XOR the byte in, then 8 unrolled LSB-first shifts.
      w_crc_upd = crc_q ^ {24'h0, in_data};
      for (int b = 0; b < 8; b++) begin
         w_crc_upd = w_crc_upd[0] ? ((w_crc_upd >> 1) ^ c_poly) : (w_crc_upd >> 1);
      end

      // Length including the current byte, saturating.
      w_len   = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + CNT_W'(1);
      w_len32 = 32'(w_len);
      w_eof   = in_valid & in_last;
      w_emit  = in_valid & (fill_q == 3'd4);

      crc_d       = crc_q;
      dly_d       = dly_q;
      fill_d      = fill_q;
      cnt_d       = cnt_q;
      phy_d       = phy_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_last_d  = 1'b0;
      done_d      = 1'b0;
      ok_d        = ok_q;
      crc_err_d   = crc_err_q;
      len_err_d   = len_err_q;
      phy_err_d   = phy_err_q;

      if (in_valid) begin
         dly_d = {dly_q[2:0], in_data};
         if (w_emit) begin
            out_valid_d = 1'b1;
            out_data_d  = dly_q[3];
            out_last_d  = w_eof;
         end
         if (w_eof) begin
            // Re-arm in the same cycle so the next frame may follow directly.
            crc_d     = 32'hFFFF_FFFF;
            fill_d    = 3'd0;
            cnt_d     = '0;
            phy_d     = 1'b0;
            done_d    = 1'b1;
            crc_err_d = (w_crc_upd != c_residue);
            len_err_d = (w_len32 < c_min_len) || (w_len32 > c_max_len);
            phy_err_d = phy_q | in_err;
            ok_d      = ~crc_err_d & ~len_err_d & ~phy_err_d;
         end else begin
            crc_d  = w_crc_upd;
            fill_d = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
            cnt_d  = w_len;
            phy_d  = phy_q | in_err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q       <= 32'hFFFF_FFFF;
         dly_q       <= '0;
         fill_q      <= 3'd0;
         cnt_q       <= '0;
         phy_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         ok_q        <= 1'b0;
         crc_err_q   <= 1'b0;
         len_err_q   <= 1'b0;
         phy_err_q   <= 1'b0;
      end else begin
         crc_q       <= crc_d;
         dly_q       <= dly_d;
         fill_q      <= fill_d;
         cnt_q       <= cnt_d;
         phy_q       <= phy_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
         ok_q        <= ok_d;
         crc_err_q   <= crc_err_d;
         len_err_q   <= len_err_d;
         phy_err_q   <= phy_err_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   assign frame_done = done_q;
   assign frame_ok   = ok_q;
   assign crc_err    = crc_err_q;
   assign len_err    = len_err_q;
   assign phy_err    = phy_err_q;

`ifdef RX_FCS_STATS_EN
   logic [CNT_W-1:0] stat_good_q;
   logic [CNT_W-1:0] stat_crc_q;

   // Counted on the same edge that registers frame_done, so the counters
   // already include the frame while its strobe is visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_good_q <= '0;
         stat_crc_q  <= '0;
      end else if (done_d) begin
         if (ok_d && (stat_good_q != c_cnt_max)) begin
            stat_good_q <= stat_good_q + CNT_W'(1);
         end
         if (crc_err_d && (stat_crc_q != c_cnt_max)) begin
            stat_crc_q <= stat_crc_q + CNT_W'(1);
         end
      end
   end

   assign stat_good    = stat_good_q;
   assign stat_crc_err = stat_crc_q;
`else
   assign stat_good    = '0;
   assign stat_crc_err = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_fcs_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_rx_fcs_check
// Purpose  : Directed self-checking bench for eth_rx_fcs_check (MIN_FRAME=13).
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_rx_fcs_check;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [7:0]       in_data;
   logic             in_last;
   logic             in_err;
   logic             out_valid;
   logic [7:0]       out_data;
   logic             out_last;
   logic             frame_done;
   logic             frame_ok;
   logic             crc_err;
   logic             len_err;
   logic             phy_err;
   logic [CNT_W-1:0] stat_good;
   logic [CNT_W-1:0] stat_crc_err;

   eth_rx_fcs_check #(
      .MIN_FRAME (13),
      .MAX_FRAME (1518),
      .CNT_W     (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_last      (in_last),
      .in_err       (in_err),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_last     (out_last),
      .frame_done   (frame_done),
      .frame_ok     (frame_ok),
      .crc_err      (crc_err),
      .len_err      (len_err),
      .phy_err      (phy_err),
      .stat_good    (stat_good),
      .stat_crc_err (stat_crc_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int stray  = 0;

   logic [8:0] rx_q[$];
   logic [8:0] exp_q[$];
   logic [3:0] st_q[$];
   logic [3:0] exp_st[$];
   int         emit_cyc[$];
   int         acc_cyc[$];
   logic [7:0] frm[$];

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (out_valid) begin
         rx_q.push_back({out_last, out_data});
         emit_cyc.push_back(cyc);
      end
      if (frame_done) st_q.push_back({frame_ok, crc_err, len_err, phy_err});
      if (out_last && !(out_valid && frame_done)) stray++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] crc_raw(input logic [7:0] f[$]);
      logic [31:0] c = 32'hFFFF_FFFF;
      foreach (f[i]) begin
         c ^= {24'h0, f[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   // Random payload of npay bytes followed by its FCS; optionally corrupted.
   task automatic build(input int npay, input bit bad);
      logic [31:0] fcs;
      frm.delete();
      for (int i = 0; i < npay; i++) frm.push_back(8'($urandom_range(0, 255)));
      fcs = ~crc_raw(frm);
      frm.push_back(fcs[7:0]);
      frm.push_back(fcs[15:8]);
      frm.push_back(fcs[23:16]);
      frm.push_back(fcs[31:24]);
      if (bad) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
   endtask

   task automatic expect_frame(input int err_idx);
      int n = frm.size();
      bit cb, lb, pb;
      for (int i = 0; i < n - 4; i++) exp_q.push_back({(i == n - 5), frm[i]});
      cb = (crc_raw(frm) != 32'hDEBB20E3);
      lb = (n < 13) || (n > 1518);
      pb = (err_idx >= 0) && (err_idx < n);
      exp_st.push_back({~(cb | lb | pb), cb, lb, pb});
   endtask

   task automatic send(input int err_idx, input int gap_pct, input int nbytes);
      for (int i = 0; i < nbytes; i++) begin
         for (int g = 0; g < 3 && $urandom_range(0, 99) < gap_pct; g++) begin
            @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
         end
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = frm[i];
         in_last  = (i == frm.size() - 1);
         in_err   = (i == err_idx);
         acc_cyc.push_back(cyc + 1);
      end
   endtask

   task automatic drain();
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic cmp_stream(input string tag);
      chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
         chk({tag, "_byte"}, {23'h0, rx_q[i]}, {23'h0, exp_q[i]});
      chk({tag, "_nframes"}, st_q.size(), exp_st.size());
      for (int i = 0; i < st_q.size() && i < exp_st.size(); i++)
         chk({tag, "_status"}, {28'h0, st_q[i]}, {28'h0, exp_st[i]});
      rx_q.delete(); exp_q.delete(); st_q.delete(); exp_st.delete();
   endtask

   task automatic set_t1(input logic [7:0] last_byte);
      frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'h00};
      frm[12] = last_byte;
      for (int i = 0; i < 9; i++) exp_q.push_back({(i == 8), 8'(8'h31 + i)});
   endtask

   initial begin
      int nA;
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; in_err = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_strobes", {29'h0, out_valid, out_last, frame_done}, 32'h0);
      chk("rst_status", {28'h0, frame_ok, crc_err, len_err, phy_err}, 32'h0);
      chk("rst_data", {24'h0, out_data}, 32'h0);
      chk("rst_stats", {stat_good, stat_crc_err}, 32'h0);
      rst = 1'b0;

      // 1: "123456789" + correct FCS, no gaps; status hand-set.
      emit_cyc.delete(); acc_cyc.delete();
      set_t1(8'hCB);
      exp_st.push_back(4'b1000);
      send(-1, 0, 13);
      drain();
      chk("t1_nemit", emit_cyc.size(), 9);
      for (int k = 0; k < 9 && k < emit_cyc.size(); k++) chk("t1_latency", emit_cyc[k], acc_cyc[k+4]);
      cmp_stream("t1");
      chk("t1_hold_ok", {31'h0, frame_ok}, 32'h1);

      // 2: corrupted last FCS byte.
      set_t1(8'hCA);
      exp_st.push_back(4'b0100);
      send(-1, 0, 13);
      drain();
      cmp_stream("t2");

      // 3: PHY error on byte 3, then a 3-byte runt right behind it.
      set_t1(8'hCB);
      exp_st.push_back(4'b0001);
      send(2, 0, 13);
      frm = '{8'hAA, 8'hBB, 8'hCC};
      exp_st.push_back(4'b0110);
      send(-1, 0, 3);
      drain();
      cmp_stream("t3");

      // in_last without in_valid must be ignored.
      @(negedge clk); in_last = 1'b1; in_data = 8'h5A;
      @(negedge clk); in_last = 1'b0;
      drain();
      chk("ghost_last", st_q.size(), 0);

      // 4: two 64-byte frames back-to-back with random gaps.
      emit_cyc.delete(); acc_cyc.delete();
      build(60, 1'b0); expect_frame(-1); send(-1, 30, 64);
      build(60, 1'b0); expect_frame(-1); send(-1, 30, 64);
      drain();
      chk("t4_nemit", emit_cyc.size(), 120);
      for (int j = 0; j < 120 && j < emit_cyc.size(); j++)
         chk("t4_latency", emit_cyc[j], acc_cyc[(j / 60) * 64 + (j % 60) + 4]);
      cmp_stream("t4");

      // Length boundaries: one byte below MIN_FRAME, one above MAX_FRAME.
      build(8, 1'b0); expect_frame(-1); send(-1, 0, 12);
      build(1515, 1'b0); expect_frame(-1); send(-1, 0, 1519);
      drain();
      cmp_stream("len_bound");

`ifdef RX_FCS_STATS_EN
      chk("stats_pre_good", {16'h0, stat_good}, 32'd3);
      chk("stats_pre_crc", {16'h0, stat_crc_err}, 32'd2);
`else
      chk("stats_pre_good", {16'h0, stat_good}, 32'd0);
      chk("stats_pre_crc", {16'h0, stat_crc_err}, 32'd0);
`endif

      // 5: reset after 20 bytes; the 16 already-emitted bytes stay emitted.
      build(60, 1'b0);
      for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, frm[i]});
      send(-1, 0, 20);
      @(negedge clk); in_valid = 1'b0; rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t5_rst_status", {28'h0, frame_ok, crc_err, len_err, phy_err}, 32'h0);
      chk("t5_rst_stats", {stat_good, stat_crc_err}, 32'h0);
      nA = 0;
      build(60, 1'b0); expect_frame(-1); send(-1, 20, 64);
      drain();
      cmp_stream("t5");

      // 6: two more good and two CRC-bad frames.
      build(50, 1'b1); expect_frame(-1); send(-1, 10, 54);
      build(50, 1'b0); expect_frame(-1); send(-1, 10, 54);
      build(50, 1'b1); expect_frame(-1); send(-1, 10, 54);
      build(50, 1'b0); expect_frame(-1); send(-1, 10, 54);
      drain();
      cmp_stream("t6");
`ifdef RX_FCS_STATS_EN
      chk("stat_good", {16'h0, stat_good}, 32'd3);
      chk("stat_crc_err", {16'h0, stat_crc_err}, 32'd2);
`else
      chk("stat_good", {16'h0, stat_good}, 32'd0 + nA);
      chk("stat_crc_err", {16'h0, stat_crc_err}, 32'd0);
`endif
      chk("stray_out_last", stray, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
